// File: rtl/shiftadd_mult_pkg.sv
// Shared types and constants for the radix-2 shift-and-add multiplier.
package shiftadd_mult_pkg;

  localparam int DEFAULT_WIDTH = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width; kept at least one bit wide for degenerate widths.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shiftadd_mult_if.sv
// Request/result bundle for shiftadd_mult; the requester owns start/A/B.
interface shiftadd_mult_if
  import shiftadd_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  // Handshake: start is a request sampled only while busy=0; a request seen
  // while busy=1 is dropped. done pulses for one cycle with P valid, and P
  // then holds until the next completion.
  logic               start;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2*WIDTH-1:0] P;
  logic               busy;
  logic               done;

  modport master (output start, A, B, input P, busy, done);
  modport slave  (input start, A, B, output P, busy, done);

endinterface

// File: rtl/shiftadd_mult_step.sv
// One radix-2 iteration: conditional add of the multiplicand, then a right shift.
module mult_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] a_reg,
  output logic [WIDTH-1:0] next_hi,
  output logic [WIDTH-1:0] next_lo
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_reg} : '0);
    // The carry of the add lands in the top bit of the shifted accumulator.
    next_hi = sum[WIDTH:1];
    next_lo = {sum[0], acc_lo[WIDTH-1:1]};
  end

endmodule

// File: rtl/shiftadd_mult.sv
// Sequential shift-and-add multiplier: FSM, iteration counter, operand and product registers.
module shiftadd_mult
  import shiftadd_mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  shiftadd_mult_if.slave    bus,
  output state_t            dbg_state
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [CW-1:0]    cnt;
  logic [2*WIDTH-1:0] p_reg;
  logic             last_iter;

  mult_step #(.WIDTH(WIDTH)) u_step (
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .a_reg   (a_reg),
    .next_hi (step_hi),
    .next_lo (step_lo)
  );

  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_reg  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      p_reg  <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg  <= bus.A;
            acc_hi <= '0;
            acc_lo <= bus.B;
            cnt    <= '0;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + CW'(1);
          // Capture the result of the final iteration directly from the step logic.
          if (last_iter) p_reg <= {step_hi, step_lo};
        end
        default: ;
      endcase
    end
  end

  assign bus.P     = p_reg;
  assign bus.busy  = (state != IDLE);
  assign bus.done  = (state == DONE);
  assign dbg_state = state;

endmodule

// File: doc/shiftadd_mult.md
# shiftadd_mult

Sequential radix-2 shift-and-add multiplier, the forward counterpart of the non-restoring divider in the RSA datapath. It takes two WIDTH-bit unsigned operands on a start pulse and retires one multiplier bit per clock. After WIDTH iterations it presents the 2·WIDTH-bit product with a one-cycle done pulse. It feeds the modular-reduction stage, where the divider's remainder output performs the reduction.

## Interface
- WIDTH, 512, operand width in bits; product is 2·WIDTH.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- A  in  WIDTH  multiplicand, unsigned; captured on accepted start.
- B  in  WIDTH  multiplier, unsigned; captured on accepted start.
- P  out  2·WIDTH  product; holds last completed result.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse, high only in DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN when start=1 at an edge.
  - On that edge: latch A into a_reg.
  - Load the low half of the accumulator with B.
  - Clear the high half and carry.
  - Set cnt=0.
- RUN, each edge:
  - sum = {1'b0, acc_hi} + (acc_lo[0] ? a_reg : 0), computed WIDTH+1 bits wide.
  - {acc_hi, acc_lo} ← {sum, acc_lo} >> 1; the carry becomes bit 2·WIDTH−1.
  - cnt ← cnt+1.
- RUN → DONE on the edge where cnt = WIDTH−1 (the last iteration).
  - On the same edge, P ← the final {acc_hi, acc_lo}.
- DONE → IDLE unconditionally on the next edge.
- start while busy=1 is ignored, not queued.
  - start still high in the IDLE cycle after DONE is accepted as a new request.
- The input A/B may change freely after acceptance; only the latched copies are used.
- No overflow is possible: the product always fits in 2·WIDTH bits.
- cnt width is clog2(WIDTH).

## Timing
- Reset values:
  - State IDLE.
  - P=0, busy=0, done=0.
  - a_reg, acc and cnt are 0.
- Latency:
  - Start is accepted at edge E0.
  - Iterations occur at edges E1..E_WIDTH.
  - done=1 and the valid P hold during the cycle after E_WIDTH, i.e. WIDTH+1 edges after acceptance.
- Throughput: one product per WIDTH+2 cycles when start is held high.
- P holds its value from the DONE entry until the next DONE entry.
  - P is not cleared by a new start.
- busy rises the cycle after acceptance and falls together with done.
- Reset mid-operation:
  - The operation aborts immediately.
  - No done pulse is issued.
  - P is cleared to 0.
- Reset and start asserted on the same edge: reset wins, state IDLE.

## Structure
- Package shiftadd_mult_pkg holds:
  - The state enum (IDLE, RUN, DONE).
  - The default WIDTH localparam.
  - A CNT_W function/constant.
- One natural sub-module, mult_step:
  - Combinational conditional add plus right shift.
  - Inputs: acc_hi, acc_lo, a_reg.
  - Output: the next {acc_hi, acc_lo}.
  - It is isolated so that a future radix-4/Booth variant can replace it.
- Top module holds the FSM, counter, operand and product registers.

## Test plan
- WIDTH=8, A=255, B=255, one start pulse:
  - done pulses exactly 9 edges after acceptance.
  - P=16'hFE01.
  - busy is high for 9 cycles.
- WIDTH=8, zero and identity cases:
  - A=0, B=200 → P=0.
  - A=1, B=200 → P=200.
  - A=200, B=1 → P=200.
- WIDTH=8, A=13, B=11, then start re-pulsed at cycles 3 and 5 with A=B=2:
  - Exactly one done with P=143.
  - The later pulses are ignored.
- WIDTH=8, A=100, B=50, rst_n low for one edge at iteration 4:
  - No done pulse.
  - P=0, busy=0.
  - A following start with A=7, B=6 yields P=42.
- WIDTH=512:
  - Case 1: A=2^512−1, B=2^512−1 → P=2^1024 − 2^513 + 1, done 513 edges after acceptance.
  - Case 2: a random operand pair checked against the behavioural product.
  - Case 3: the product is fed to the divider by B and must return quotient=A, remainder=0.
